// File: rtl/csr_file.sv
// -----------------------------------------------------------------------------
// csr_file -- machine-mode CSR register file for a small RV32I core.
//
// Optional feature macro: CSR_COUNTERS_EN
//   defined   -> 64-bit mcycle / minstret counters are implemented
//   undefined -> counter addresses are unimplemented (read 0, illegal_csr=1)
//
// Ports
//   clk          in   1   single clock, all state updates on rising edge
//   reset        in   1   synchronous active-high reset
//   csr          in   1   CSR instruction this cycle (read strobe + write enable)
//   csr_rd_addr  in  12   CSR address used for both read and write
//   csr_wr_data  in  32   write value from the core ALU
//   csr_rd_data  out 32   combinational read value (0 when idle or unimplemented)
//   trap         in   1   ebreak in execute this cycle
//   pc           in  32   PC of the executing instruction
//   retire       in   1   instruction completes this cycle
//   trap_vector  out 32   current mtvec
//   mepc_out     out 32   current mepc
//   illegal_csr  out  1   csr access to an unimplemented address
// -----------------------------------------------------------------------------
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr,
    input  logic [11:0] csr_rd_addr,
    input  logic [31:0] csr_wr_data,
    output logic [31:0] csr_rd_data,
    input  logic        trap,
    input  logic [31:0] pc,
    input  logic        retire,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_out,
    output logic        illegal_csr
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VALUE     = 32'h4000_0100;
    localparam logic [31:0] CAUSE_BREAK    = 32'd3;

    // mtvec/mepc keep only the word-aligned part; bits [1:0] are implied zero
    logic        mie_r;
    logic        mpie_r;
    logic [29:0] mtvec_r;
    logic [31:0] mscratch_r;
    logic [29:0] mepc_r;
    logic [31:0] mcause_r;

    logic        wr_en_s;
    logic [31:0] mstatus_s;
    logic [31:0] rd_val_s;
    logic        impl_s;
    logic        unused_bits_s;

    // A trap in the same cycle drops the CSR write entirely
    assign wr_en_s = csr & ~trap;

    // MPP is hard-wired to machine mode; only MIE and MPIE hold state
    assign mstatus_s = {19'd0, 2'b11, 3'd0, mpie_r, 3'd0, mie_r, 3'd0};

    assign trap_vector = {mtvec_r, 2'b00};
    assign mepc_out    = {mepc_r, 2'b00};

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_r;
    logic [63:0] minstret_r;

    // mcycle: a half-write replaces that half and skips this cycle's increment
    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle_r <= 64'd0;
        end else if (wr_en_s && (csr_rd_addr == ADDR_MCYCLE)) begin
            mcycle_r[31:0] <= csr_wr_data;
        end else if (wr_en_s && (csr_rd_addr == ADDR_MCYCLEH)) begin
            mcycle_r[63:32] <= csr_wr_data;
        end else begin
            mcycle_r <= mcycle_r + 64'd1;
        end
    end

    // minstret: counts retirements that did not trap, same write rules as mcycle
    always_ff @(posedge clk) begin
        if (reset) begin
            minstret_r <= 64'd0;
        end else if (wr_en_s && (csr_rd_addr == ADDR_MINSTRET)) begin
            minstret_r[31:0] <= csr_wr_data;
        end else if (wr_en_s && (csr_rd_addr == ADDR_MINSTRETH)) begin
            minstret_r[63:32] <= csr_wr_data;
        end else if (retire && !trap) begin
            minstret_r <= minstret_r + 64'd1;
        end else begin
            minstret_r <= minstret_r;
        end
    end

    assign unused_bits_s = ^pc[1:0];
`else
    assign unused_bits_s = ^{pc[1:0], retire};
`endif

    // Trap entry state and the trap-related CSRs; trap beats any CSR write
    always_ff @(posedge clk) begin
        if (reset) begin
            mie_r    <= 1'b0;
            mpie_r   <= 1'b0;
            mepc_r   <= 30'd0;
            mcause_r <= 32'd0;
        end else if (trap) begin
            mepc_r   <= pc[31:2];
            mcause_r <= CAUSE_BREAK;
            mpie_r   <= mie_r;
            mie_r    <= 1'b0;
        end else begin
            if (wr_en_s && (csr_rd_addr == ADDR_MSTATUS)) begin
                mie_r  <= csr_wr_data[3];
                mpie_r <= csr_wr_data[7];
            end
            if (wr_en_s && (csr_rd_addr == ADDR_MEPC)) begin
                mepc_r <= csr_wr_data[31:2];
            end
            if (wr_en_s && (csr_rd_addr == ADDR_MCAUSE)) begin
                mcause_r <= csr_wr_data;
            end
        end
    end

    // Plain software-written registers: mtvec and mscratch
    always_ff @(posedge clk) begin
        if (reset) begin
            mtvec_r    <= MTVEC_RESET[31:2];
            mscratch_r <= 32'd0;
        end else begin
            if (wr_en_s && (csr_rd_addr == ADDR_MTVEC)) begin
                mtvec_r <= csr_wr_data[31:2];
            end
            if (wr_en_s && (csr_rd_addr == ADDR_MSCRATCH)) begin
                mscratch_r <= csr_wr_data;
            end
        end
    end

    // Address decode: read value and whether the address exists
    always_comb begin
        rd_val_s = 32'd0;
        impl_s   = 1'b0;
        case (csr_rd_addr)
            ADDR_MSTATUS:   begin rd_val_s = mstatus_s;           impl_s = 1'b1; end
            ADDR_MISA:      begin rd_val_s = MISA_VALUE;          impl_s = 1'b1; end
            ADDR_MTVEC:     begin rd_val_s = {mtvec_r, 2'b00};    impl_s = 1'b1; end
            ADDR_MSCRATCH:  begin rd_val_s = mscratch_r;          impl_s = 1'b1; end
            ADDR_MEPC:      begin rd_val_s = {mepc_r, 2'b00};     impl_s = 1'b1; end
            ADDR_MCAUSE:    begin rd_val_s = mcause_r;            impl_s = 1'b1; end
            ADDR_MHARTID:   begin rd_val_s = HART_ID;             impl_s = 1'b1; end
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    begin rd_val_s = mcycle_r[31:0];      impl_s = 1'b1; end
            ADDR_MCYCLEH:   begin rd_val_s = mcycle_r[63:32];     impl_s = 1'b1; end
            ADDR_MINSTRET:  begin rd_val_s = minstret_r[31:0];    impl_s = 1'b1; end
            ADDR_MINSTRETH: begin rd_val_s = minstret_r[63:32];   impl_s = 1'b1; end
`endif
            default:        begin rd_val_s = 32'd0;               impl_s = 1'b0; end
        endcase
    end

    // Outputs are qualified by the access strobe
    always_comb begin
        csr_rd_data = 32'd0;
        illegal_csr = 1'b0;
        if (csr) begin
            csr_rd_data = rd_val_s;
            illegal_csr = ~impl_s;
        end else begin
            csr_rd_data = 32'd0;
            illegal_csr = 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

    localparam logic [31:0] HART = 32'h0000_00A7;
    localparam logic [31:0] MTVR = 32'h0000_1003;
    localparam logic [31:0] MTVR_EXP = 32'h0000_1000;
    localparam logic [31:0] MISA = 32'h4000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr = 1'b0;
    logic [11:0] csr_rd_addr = 12'h000;
    logic [31:0] csr_wr_data = 32'h0;
    logic [31:0] csr_rd_data;
    logic        trap = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        retire = 1'b0;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;
    logic        illegal_csr;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_v;
    logic [31:0] got_v;
    logic        ill_v;

    csr_file #(.HART_ID(HART), .MTVEC_RESET(MTVR)) dut (
        .clk(clk), .reset(reset), .csr(csr), .csr_rd_addr(csr_rd_addr),
        .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data), .trap(trap),
        .pc(pc), .retire(retire), .trap_vector(trap_vector),
        .mepc_out(mepc_out), .illegal_csr(illegal_csr)
    );

    always #5 clk = ~clk;

    // Read: strobe csr only between edges so no write can happen
    task automatic rd_csr(input logic [11:0] a, output logic [31:0] d, output logic il);
        @(negedge clk);
        csr = 1'b1; csr_rd_addr = a; csr_wr_data = 32'h0;
        #1;
        d = csr_rd_data; il = illegal_csr;
        csr = 1'b0;
    endtask

    // Write: csr held across one rising edge; returns the same-cycle read value
    task automatic wr_csr(input logic [11:0] a, input logic [31:0] v,
                          output logic [31:0] old, output logic il);
        @(negedge clk);
        csr = 1'b1; csr_rd_addr = a; csr_wr_data = v;
        #1;
        old = csr_rd_data; il = illegal_csr;
        @(negedge clk);
        csr = 1'b0; csr_wr_data = 32'h0;
    endtask

    task automatic test_reset();
        logic [11:0] a [0:6];
        a[0] = 12'h300; a[1] = 12'h301; a[2] = 12'h305; a[3] = 12'h340;
        a[4] = 12'h341; a[5] = 12'h342; a[6] = 12'hF14;
        repeat (3) @(negedge clk);
        reset = 1'b0;
`ifdef CSR_COUNTERS_EN
        sb_q.push_back(32'd1);
        rd_csr(12'hB00, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL reset_mcycle got=%h want=%h", got_v, exp_v); end
        sb_q.push_back(32'd0);
        rd_csr(12'hB02, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL reset_minstret got=%h want=%h", got_v, exp_v); end
`endif
        sb_q.push_back(32'h0000_1800); sb_q.push_back(MISA); sb_q.push_back(MTVR_EXP);
        sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(HART);
        for (int i = 0; i < 7; i++) begin
            rd_csr(a[i], got_v, ill_v);
            exp_v = sb_q.pop_front(); total++;
            if (got_v !== exp_v || ill_v !== 1'b0) begin
                bad++; $display("FAIL reset_rd[%03h] got=%h/%b want=%h/0", a[i], got_v, ill_v, exp_v);
            end
        end
        sb_q.push_back(MTVR_EXP); sb_q.push_back(32'h0);
        exp_v = sb_q.pop_front(); total++;
        if (trap_vector !== exp_v) begin bad++; $display("FAIL reset_trap_vector got=%h want=%h", trap_vector, exp_v); end
        exp_v = sb_q.pop_front(); total++;
        if (mepc_out !== exp_v) begin bad++; $display("FAIL reset_mepc_out got=%h want=%h", mepc_out, exp_v); end
    endtask

    task automatic test_mtvec();
        sb_q.push_back(MTVR_EXP);
        sb_q.push_back(32'h8000_0100);
        sb_q.push_back(32'h8000_0100);
        wr_csr(12'h305, 32'h8000_0103, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL mtvec_same_cycle_old got=%h want=%h", got_v, exp_v); end
        #1;
        exp_v = sb_q.pop_front(); total++;
        if (trap_vector !== exp_v) begin bad++; $display("FAIL mtvec_trap_vector got=%h want=%h", trap_vector, exp_v); end
        rd_csr(12'h305, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL mtvec_read got=%h want=%h", got_v, exp_v); end
    endtask

    task automatic test_trap();
        wr_csr(12'h300, 32'h0000_0008, got_v, ill_v);
        sb_q.push_back(32'h0000_1808);
        rd_csr(12'h300, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL trap_mie_set got=%h want=%h", got_v, exp_v); end
        @(negedge clk); trap = 1'b1; pc = 32'h0000_0124;
        @(negedge clk); trap = 1'b0;
        sb_q.push_back(32'h0000_0124); sb_q.push_back(32'd3); sb_q.push_back(32'h0000_1880);
        #1;
        exp_v = sb_q.pop_front(); total++;
        if (mepc_out !== exp_v) begin bad++; $display("FAIL trap_mepc_out got=%h want=%h", mepc_out, exp_v); end
        rd_csr(12'h342, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL trap_mcause got=%h want=%h", got_v, exp_v); end
        rd_csr(12'h300, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL trap_mstatus got=%h want=%h", got_v, exp_v); end
        // second trap: MPIE takes the now-clear MIE, unaligned pc is masked
        @(negedge clk); trap = 1'b1; pc = 32'h0000_0A57;
        @(negedge clk); trap = 1'b0;
        sb_q.push_back(32'h0000_0A54); sb_q.push_back(32'h0000_1800);
        #1;
        exp_v = sb_q.pop_front(); total++;
        if (mepc_out !== exp_v) begin bad++; $display("FAIL trap2_mepc_out got=%h want=%h", mepc_out, exp_v); end
        rd_csr(12'h300, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL trap2_mstatus got=%h want=%h", got_v, exp_v); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        trap = 1'b1; pc = 32'h0000_0200;
        csr = 1'b1; csr_rd_addr = 12'h340; csr_wr_data = 32'h0000_DEAD;
        @(negedge clk);
        trap = 1'b0; csr = 1'b0; csr_wr_data = 32'h0;
        sb_q.push_back(32'h0); sb_q.push_back(32'h0000_0200); sb_q.push_back(32'h0000_DEAD);
        rd_csr(12'h340, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL collide_mscratch got=%h want=%h", got_v, exp_v); end
        rd_csr(12'h341, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL collide_mepc got=%h want=%h", got_v, exp_v); end
        wr_csr(12'h340, 32'h0000_DEAD, got_v, ill_v);
        rd_csr(12'h340, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL mscratch_write got=%h want=%h", got_v, exp_v); end
    endtask

    task automatic test_masks();
        logic [11:0] a [0:3];
        logic [31:0] w [0:3];
        a[0] = 12'h300; w[0] = 32'hFFFF_FFFF; sb_q.push_back(32'h0000_1888);
        a[1] = 12'h341; w[1] = 32'h1234_5677; sb_q.push_back(32'h1234_5674);
        a[2] = 12'h342; w[2] = 32'hFFFF_FFFF; sb_q.push_back(32'hFFFF_FFFF);
        a[3] = 12'h300; w[3] = 32'h0000_0000; sb_q.push_back(32'h0000_1800);
        for (int i = 0; i < 4; i++) begin
            wr_csr(a[i], w[i], got_v, ill_v);
            rd_csr(a[i], got_v, ill_v);
            exp_v = sb_q.pop_front(); total++;
            if (got_v !== exp_v) begin bad++; $display("FAIL mask_rd[%03h] got=%h want=%h", a[i], got_v, exp_v); end
        end
        sb_q.push_back(32'h1234_5674);
        exp_v = sb_q.pop_front(); total++;
        if (mepc_out !== exp_v) begin bad++; $display("FAIL mask_mepc_out got=%h want=%h", mepc_out, exp_v); end
    endtask

    task automatic test_illegal();
        rd_csr(12'h7C0, got_v, ill_v);
        sb_q.push_back(32'h0); sb_q.push_back(32'd1);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL illegal_data got=%h want=%h", got_v, exp_v); end
        exp_v = sb_q.pop_front(); total++;
        if ({31'd0, ill_v} !== exp_v) begin bad++; $display("FAIL illegal_flag got=%b want=%0d", ill_v, exp_v); end
        // idle strobe: nothing reported even on an implemented address
        @(negedge clk); csr = 1'b0; csr_rd_addr = 12'h300; #1;
        sb_q.push_back(32'h0);
        exp_v = sb_q.pop_front(); total++;
        if (csr_rd_data !== exp_v || illegal_csr !== 1'b0) begin
            bad++; $display("FAIL idle_read got=%h/%b want=%h/0", csr_rd_data, illegal_csr, exp_v);
        end
        wr_csr(12'hF14, 32'd5, got_v, ill_v);
        sb_q.push_back(32'd0); sb_q.push_back(HART); sb_q.push_back(MISA);
        exp_v = sb_q.pop_front(); total++;
        if ({31'd0, ill_v} !== exp_v) begin bad++; $display("FAIL ro_write_flag got=%b want=%0d", ill_v, exp_v); end
        rd_csr(12'hF14, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL mhartid got=%h want=%h", got_v, exp_v); end
        wr_csr(12'h301, 32'h0, got_v, ill_v);
        rd_csr(12'h301, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL misa_ro got=%h want=%h", got_v, exp_v); end
    endtask

`ifdef CSR_COUNTERS_EN
    task automatic test_counters();
        // carry from low to high word
        wr_csr(12'hB00, 32'hFFFF_FFFE, got_v, ill_v);
        @(negedge clk);
        sb_q.push_back(32'h0); sb_q.push_back(32'd1);
        rd_csr(12'hB00, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL carry_mcycle got=%h want=%h", got_v, exp_v); end
        rd_csr(12'hB80, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL carry_mcycleh got=%h want=%h", got_v, exp_v); end
        // write edge suppresses increment: 100 then +1 on the next edge
        wr_csr(12'hB00, 32'd100, got_v, ill_v);
        sb_q.push_back(32'd101);
        rd_csr(12'hB00, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL suppress_mcycle got=%h want=%h", got_v, exp_v); end
        // 64-bit wrap
        wr_csr(12'hB80, 32'hFFFF_FFFF, got_v, ill_v);
        wr_csr(12'hB00, 32'hFFFF_FFFF, got_v, ill_v);
        sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        rd_csr(12'hB00, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL wrap_mcycle got=%h want=%h", got_v, exp_v); end
        rd_csr(12'hB80, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL wrap_mcycleh got=%h want=%h", got_v, exp_v); end
        // minstret: 10 retires, one of them trapping
        wr_csr(12'hB02, 32'h0, got_v, ill_v);
        wr_csr(12'hB82, 32'h0, got_v, ill_v);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            retire = 1'b1; trap = (i == 4); pc = 32'h0000_0400;
        end
        @(negedge clk); retire = 1'b0; trap = 1'b0;
        sb_q.push_back(32'd9); sb_q.push_back(32'd0);
        rd_csr(12'hB02, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL minstret got=%h want=%h", got_v, exp_v); end
        rd_csr(12'hB82, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL minstreth got=%h want=%h", got_v, exp_v); end
    endtask
`else
    task automatic test_counters();
        logic [11:0] a [0:3];
        a[0] = 12'hB00; a[1] = 12'hB02; a[2] = 12'hB80; a[3] = 12'hB82;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(32'h0);
            rd_csr(a[i], got_v, ill_v);
            exp_v = sb_q.pop_front(); total++;
            if (got_v !== exp_v || ill_v !== 1'b1) begin
                bad++; $display("FAIL nocnt_rd[%03h] got=%h/%b want=%h/1", a[i], got_v, ill_v, exp_v);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_trap();
        wr_csr(12'h340, 32'h0000_0055, got_v, ill_v);
        wr_csr(12'h305, 32'h0000_2000, got_v, ill_v);
        @(negedge clk);
        reset = 1'b1; trap = 1'b1; pc = 32'h0000_0300; retire = 1'b1;
        csr = 1'b1; csr_rd_addr = 12'h340; csr_wr_data = 32'h0000_0077;
        @(negedge clk);
        reset = 1'b0; trap = 1'b0; retire = 1'b0; csr = 1'b0; csr_wr_data = 32'h0;
        #1;
        sb_q.push_back(32'h0); sb_q.push_back(MTVR_EXP);
        exp_v = sb_q.pop_front(); total++;
        if (mepc_out !== exp_v) begin bad++; $display("FAIL rst_trap_mepc_out got=%h want=%h", mepc_out, exp_v); end
        exp_v = sb_q.pop_front(); total++;
        if (trap_vector !== exp_v) begin bad++; $display("FAIL rst_trap_vector got=%h want=%h", trap_vector, exp_v); end
`ifdef CSR_COUNTERS_EN
        sb_q.push_back(32'd1); sb_q.push_back(32'd0);
        rd_csr(12'hB00, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL rst_trap_mcycle got=%h want=%h", got_v, exp_v); end
        rd_csr(12'hB02, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL rst_trap_minstret got=%h want=%h", got_v, exp_v); end
`endif
        sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0000_1800);
        rd_csr(12'h342, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL rst_trap_mcause got=%h want=%h", got_v, exp_v); end
        rd_csr(12'h340, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL rst_trap_mscratch got=%h want=%h", got_v, exp_v); end
        rd_csr(12'h300, got_v, ill_v);
        exp_v = sb_q.pop_front(); total++;
        if (got_v !== exp_v) begin bad++; $display("FAIL rst_trap_mstatus got=%h want=%h", got_v, exp_v); end
    endtask

    initial begin
        test_reset();
        test_mtvec();
        test_trap();
        test_collision();
        test_masks();
        test_illegal();
        test_counters();
        test_reset_mid_trap();
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter HART_ID, default 32'h0, value returned by mhartid.
REQ-002 Parameter MTVEC_RESET, default 32'h0, reset value of mtvec (bits [1:0] forced 0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 csr  input  1  access strobe from core; high = CSR instruction this cycle.
REQ-006 csr_rd_addr  input  12  CSR address, used for both read and write.
REQ-007 csr_wr_data  input  32  write value computed by the core ALU.
REQ-008 csr_rd_data  output  32  read value, combinational from csr_rd_addr.
REQ-009 trap  input  1  ebreak in execute this cycle.
REQ-010 pc  input  32  PC of the executing instruction.
REQ-011 retire  input  1  instruction completes this cycle.
REQ-012 trap_vector  output  32  current mtvec.
REQ-013 mepc_out  output  32  current mepc.
REQ-014 illegal_csr  output  1  combinational; high when csr=1 and address unimplemented.

Function
REQ-015 Read latency SHALL be zero: csr_rd_data reflects current register state whenever csr=1; csr=0 or unimplemented address -> 32'h0.
REQ-016 When csr=1, no trap, and address writable, the register SHALL load csr_wr_data at the next rising edge; the same-cycle read returns the old value.
REQ-017 Address map: mstatus 0x300, misa 0x301 RO, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mhartid 0xF14 RO.
REQ-018 Writes to RO addresses SHALL be silently ignored, without illegal_csr.
REQ-019 mstatus: only MIE (bit 3) and MPIE (bit 7) writable; MPP [12:11] reads constant 2'b11; other bits read 0.
REQ-020 misa SHALL read 32'h40000100 (RV32I); mhartid SHALL read HART_ID.
REQ-021 mtvec and mepc SHALL store bits [1:0] as 0 regardless of written data.
REQ-022 On trap=1: mepc <= pc & ~3, mcause <= 32'd3, MPIE <= MIE, MIE <= 0, all in one cycle.
REQ-023 Trap and CSR write in the same cycle: trap updates win; the CSR write is dropped entirely.
REQ-024 mcycle SHALL be a 64-bit counter incrementing every cycle out of reset; carry from low word into mcycleh on the same edge.
REQ-025 minstret SHALL be a 64-bit counter incrementing when retire=1 and trap=0.
REQ-026 A write to a counter half SHALL load that half and suppress that cycle's increment of the whole 64-bit counter; the other half holds.
REQ-027 Counters SHALL wrap 0xFFFFFFFF_FFFFFFFF -> 0 without a flag.
REQ-028 trap_vector and mepc_out SHALL be direct register outputs, no added latency.

Reset
REQ-029 reset=1 at a rising edge overrides trap, csr and retire that cycle.
REQ-030 Reset values: mstatus 32'h00001800, mtvec MTVEC_RESET & ~3, mscratch/mepc/mcause 0, all counters 0.
REQ-031 Counters SHALL first increment on the first edge after reset deasserts.
REQ-032 Reset asserted mid-trap SHALL leave mepc/mcause at reset values.

Configuration
REQ-033 Macro CSR_COUNTERS_EN: defined -> mcycle/mcycleh/minstret/minstreth implemented per REQ-024..027.
REQ-034 Without CSR_COUNTERS_EN: counter registers absent, their addresses read 0, illegal_csr asserted on access.

Verification
REQ-035 Reset, then csr=1 addr 0x305 wr 32'h80000103 -> next cycle trap_vector = 32'h80000100.
REQ-036 Set MIE via 0x300 wr 32'h8; trap=1, pc=32'h0000_0124 -> mepc_out=32'h124, mcause=3, mstatus reads 32'h1880.
REQ-037 Same cycle trap=1 and csr=1 addr 0x340 wr 32'hDEAD -> mscratch stays 0, mepc updated.
REQ-038 Write 0xB00 = 32'hFFFFFFFE; two cycles later mcycle=0, mcycleh=1 (CSR_COUNTERS_EN defined).
REQ-039 csr=1 addr 0x7C0 -> illegal_csr=1, csr_rd_data=0; addr 0xF14 wr 5 -> illegal_csr=0, reads HART_ID.
REQ-040 retire=1 for 10 cycles with trap high in one of them -> minstret=9.
